// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: the FSM state
// encoding, the default instruction-memory capacity, and the framing
// constants of the load stream. The stream is a two-byte word count N,
// N big-endian 32-bit words, and one XOR checksum byte.
package imem_loader_pkg;

  // Default capacity in 32-bit words (1 KB of instruction memory).
  localparam int MAX_WORDS_DEFAULT = 256;

  // Stream framing.
  localparam int HDR_BYTES      = 2;
  localparam int CSUM_BYTES     = 1;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

endpackage

// File: rtl/imem_loader_word_pack.sv
// word_pack
// Assembles incoming stream bytes into a 32-bit big-endian word. The first
// byte of a word ends up in bits 31:24.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-low reset
//   clear     - zero the byte counter and word register
//   shift_en  - a byte is being accepted this cycle
//   byte_in   - the byte being accepted
//   word      - the word assembled so far
//   word_full - this cycle's accepted byte completes the word
module word_pack
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = {word_q[23:0], byte_in};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word = word_q;

  // Combinational so the FSM can leave DATA on the same edge that latches
  // the fourth byte; the counter wraps to zero on its own at that edge.
  assign word_full = shift_en && !clear && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Receives a byte stream (N high, N low, N big-endian words, XOR checksum),
// writes each word into instruction memory, and releases the processor
// reset only after a load completes with a matching checksum.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   start    - begin a load (sampled in IDLE/DONE/ERR)
//   rx_valid - rx_data holds a valid byte
//   rx_data  - stream byte
//   rx_ready - loader accepts a byte this cycle
//   im_we    - one-cycle instruction-memory write strobe
//   im_addr  - word-aligned byte address of the write
//   im_wdata - word being written
//   cpu_rst  - active-high core reset, low only in DONE
//   done     - load finished with good checksum
//   err      - load aborted (oversized N or bad checksum)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [9:0]  im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  // Wide enough to count up to MAX_WORDS itself.
  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  state_e             state_q, state_d;
  logic [15:0]        n_q, n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   idx_inc;
  logic [7:0]         xor_q, xor_d;
  logic [9:0]         addr_hold_q, addr_hold_d;
  logic [31:0]        data_hold_q, data_hold_d;

  logic [15:0]        n_full;
  logic [9:0]         addr_cur;
  logic               pack_clear;
  logic               pack_shift;
  logic [31:0]        pack_word;
  logic               pack_full;

  word_pack u_word_pack (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .shift_en  (pack_shift),
    .byte_in   (rx_data),
    .word      (pack_word),
    .word_full (pack_full)
  );

  assign n_full   = {n_q[15:8], rx_data};
  assign idx_inc  = idx_q + IDX_W'(1);
  assign addr_cur = 10'(idx_q) << 2;

  // Next-state logic. Every state shares the same "start a new load"
  // behaviour from IDLE/DONE/ERR, which also wipes the per-load counters.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    addr_hold_d = addr_hold_q;
    data_hold_d = data_hold_q;
    rx_ready    = 1'b0;
    pack_clear  = 1'b0;
    pack_shift  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR0;
          idx_d      = '0;
          xor_d      = '0;
          pack_clear = 1'b1;
        end
      end

      ST_HDR0: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          n_d     = {rx_data, n_q[7:0]};
          state_d = ST_HDR1;
        end
      end

      ST_HDR1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          n_d = n_full;
          if (32'(n_full) > MAX_WORDS) begin
            state_d = ST_ERR;
          end else if (n_full == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          pack_shift = 1'b1;
          xor_d      = xor_q ^ rx_data;
          if (pack_full) begin
            state_d = ST_WRITE;
          end
        end
      end

      // The strobe cycle: remember address/data so the outputs keep
      // showing the last write after we leave.
      ST_WRITE: begin
        addr_hold_d = addr_cur;
        data_hold_d = pack_word;
        idx_d       = idx_inc;
        pack_clear  = 1'b1;
        if (16'(idx_inc) == n_q) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          state_d = (rx_data == xor_q) ? ST_DONE : ST_ERR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

  assign im_we    = (state_q == ST_WRITE);
  assign im_addr  = im_we ? addr_cur  : addr_hold_q;
  assign im_wdata = im_we ? pack_word : data_hold_q;
  assign cpu_rst  = (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader. Loads are described as a word count,
// a list of words and a checksum byte; the reference model turns that into
// the expected byte stream, the expected list of memory writes and the
// expected final status. Bytes are offered with random gaps, and random
// garbage is offered while the loader is not ready.
module tb_imem_loader;

  localparam int MAX_W = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] words_q[$];
  logic [7:0]  stream_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [9:0]  got_addr_q[$];
  logic [31:0] got_data_q[$];
  logic        exp_done;

  always #5 clk = ~clk;

  imem_loader #(.MAX_WORDS(MAX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  // Record every write strobe seen by the memory.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      got_addr_q.push_back(im_addr);
      got_data_q.push_back(im_wdata);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: build the byte stream and expected results from
  // words_q, the header value n and the checksum byte.
  task automatic prepare(input logic [15:0] n, input logic [7:0] csum);
    logic [7:0]  x;
    logic [31:0] w;
    stream_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    stream_q.push_back(n[15:8]);
    stream_q.push_back(n[7:0]);
    if (int'(n) > MAX_W) begin
      exp_done = 1'b0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      w = words_q[i];
      stream_q.push_back(w[31:24]);
      stream_q.push_back(w[23:16]);
      stream_q.push_back(w[15:8]);
      stream_q.push_back(w[7:0]);
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp_addr_q.push_back(10'(i * 4));
      exp_data_q.push_back(w);
    end
    stream_q.push_back(csum);
    exp_done = (csum == x);
  endtask

  function automatic logic [7:0] payload_xor(input int n);
    logic [7:0]  x;
    logic [31:0] w;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = words_q[i];
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    return x;
  endfunction

  // Offer the first 'limit' stream bytes; pct is the chance per cycle that
  // rx_valid is raised. Returns after the edge that takes the last byte.
  task automatic send_stream(input int pct, input int limit, input string tag);
    int  idx    = 0;
    int  budget = 0;
    bit  go;
    while (idx < limit && budget < 20000) begin
      @(negedge clk);
      budget++;
      go = ($urandom_range(99) < pct);
      rx_valid = go;
      if (rx_ready && go) begin
        rx_data = stream_q[idx];
        idx++;
      end else begin
        rx_data = 8'($urandom);
      end
    end
    @(posedge clk);
    if (idx < limit) check_output({tag, " stream_timeout"}, idx, limit);
  endtask

  task automatic wait_and_check(input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      rx_valid = 1'b0;
      cyc++;
    end while (!(done || err) && cyc < 50);
    if (!(done || err)) check_output({tag, " end_timeout"}, 0, 1);
    check_output({tag, " done"}, done, exp_done);
    check_output({tag, " err"}, err, !exp_done);
    check_output({tag, " cpu_rst"}, cpu_rst, !exp_done);
    check_output({tag, " rx_ready"}, rx_ready, 0);
    check_output({tag, " im_we"}, im_we, 0);
    check_output({tag, " nwrites"}, got_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < got_addr_q.size(); i++) begin
      check_output($sformatf("%s waddr%0d", tag, i), got_addr_q[i], exp_addr_q[i]);
      check_output($sformatf("%s wdata%0d", tag, i), got_data_q[i], exp_data_q[i]);
    end
  endtask

  task automatic pulse_start(input string tag);
    got_addr_q.delete();
    got_data_q.delete();
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output({tag, " start_cpu_rst"}, cpu_rst, 1);
    check_output({tag, " start_done"}, done, 0);
    check_output({tag, " start_err"}, err, 0);
  endtask

  task automatic apply_stimulus(input string tag, input int pct);
    pulse_start(tag);
    send_stream(pct, stream_q.size(), tag);
    wait_and_check(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " rx_ready"}, rx_ready, 0);
    check_output({tag, " im_we"}, im_we, 0);
    check_output({tag, " im_addr"}, im_addr, 0);
    check_output({tag, " im_wdata"}, im_wdata, 0);
    check_output({tag, " done"}, done, 0);
    check_output({tag, " err"}, err, 0);
    check_output({tag, " cpu_rst"}, cpu_rst, 1);
  endtask

  initial begin
    logic [15:0] n;
    logic [7:0]  cs;

    rst      = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Two-word example; the XOR of its eight payload bytes is 0x08.
    words_q.delete();
    words_q.push_back(32'h3C080010);
    words_q.push_back(32'h21090004);
    prepare(16'd2, 8'h08);
    apply_stimulus("two_words_good", 100);
    prepare(16'd2, 8'h00);
    apply_stimulus("two_words_csum00", 70);
    prepare(16'd2, 8'h55);
    apply_stimulus("two_words_csum55", 70);

    // Oversized header aborts right after the second header byte.
    prepare(16'd257, 8'h00);
    apply_stimulus("hdr_257", 80);

    // Empty image.
    words_q.delete();
    prepare(16'd0, 8'h00);
    apply_stimulus("empty", 80);

    // Full-capacity image.
    words_q.delete();
    for (int i = 0; i < MAX_W; i++) words_q.push_back($urandom);
    prepare(16'd256, payload_xor(MAX_W));
    apply_stimulus("full", 90);
    if (got_addr_q.size() > 0)
      check_output("full last_addr", got_addr_q[got_addr_q.size()-1], 10'h3FC);
    else
      check_output("full last_addr", 32'hFFFF_FFFF, 10'h3FC);

    // Random loads, some with a corrupted checksum.
    for (int t = 0; t < 8; t++) begin
      n = 16'($urandom_range(1, 12));
      words_q.delete();
      for (int i = 0; i < int'(n); i++) words_q.push_back($urandom);
      cs = payload_xor(int'(n));
      if ($urandom_range(1) == 1) cs = cs ^ 8'($urandom_range(1, 255));
      prepare(n, cs);
      apply_stimulus($sformatf("rand%0d", t), $urandom_range(30, 100));
    end

    // Reset after the sixth payload byte, with start and rx_valid also
    // high on that edge; then reload the same image.
    words_q.delete();
    words_q.push_back($urandom);
    words_q.push_back($urandom);
    prepare(16'd2, payload_xor(2));
    pulse_start("midreset");
    send_stream(60, 8, "midreset");
    @(negedge clk);
    rst      = 1'b0;
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    apply_stimulus("reload", 50);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
